// File: rtl/axi_lite_rvc_regs_if.sv
// AXI4-Lite channel bundle for the RVC register block.
// slave: responder side; master: requester side.
interface axi_lite_rvc_regs_if #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiStrbWidth = 16
);
  logic [AxiAddrWidth-1:0] aw_addr_i;
  logic [2:0]              aw_prot_i;
  logic                    aw_valid_i;
  logic                    aw_ready_o;
  logic [AxiDataWidth-1:0] w_data_i;
  logic [AxiStrbWidth-1:0] w_strb_i;
  logic                    w_valid_i;
  logic                    w_ready_o;
  logic [1:0]              b_resp_o;
  logic                    b_valid_o;
  logic                    b_ready_i;
  logic [AxiAddrWidth-1:0] ar_addr_i;
  logic [2:0]              ar_prot_i;
  logic                    ar_valid_i;
  logic                    ar_ready_o;
  logic [AxiDataWidth-1:0] r_data_o;
  logic [1:0]              r_resp_o;
  logic                    r_valid_o;
  logic                    r_ready_i;

  modport slave (
    input  aw_addr_i, aw_prot_i, aw_valid_i,
    output aw_ready_o,
    input  w_data_i, w_strb_i, w_valid_i,
    output w_ready_o,
    output b_resp_o, b_valid_o,
    input  b_ready_i,
    input  ar_addr_i, ar_prot_i, ar_valid_i,
    output ar_ready_o,
    output r_data_o, r_resp_o, r_valid_o,
    input  r_ready_i
  );

  modport master (
    output aw_addr_i, aw_prot_i, aw_valid_i,
    input  aw_ready_o,
    output w_data_i, w_strb_i, w_valid_i,
    input  w_ready_o,
    input  b_resp_o, b_valid_o,
    output b_ready_i,
    output ar_addr_i, ar_prot_i, ar_valid_i,
    input  ar_ready_o,
    input  r_data_o, r_resp_o, r_valid_o,
    output r_ready_i
  );
endinterface

// File: rtl/axi_lite_rvc_regs.sv
// AXI4-Lite register file for a Root Voter Cell: CTRL, STATUS,
// MISMATCH_CNT, TIMEOUT, SCRATCH. Ports: clk_i, rst_ni, bus (slave),
// status_i, mismatch_i, enable_o, timeout_o.
module axi_lite_rvc_regs #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiStrbWidth = 16,
  parameter logic [31:0] TimeoutRst   = 32'h0000_FFFF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  axi_lite_rvc_regs_if.slave  bus,
  input  logic [7:0]          status_i,
  input  logic                mismatch_i,
  output logic                enable_o,
  output logic [31:0]         timeout_o
);
  localparam int unsigned Lanes = AxiDataWidth / 32;
  localparam logic [5:0] LaneMask = 6'(Lanes - 1);

  localparam logic [2:0] W_IDLE    = 3'd0;
  localparam logic [2:0] W_HAVE_AW = 3'd1;
  localparam logic [2:0] W_HAVE_W  = 3'd2;
  localparam logic [2:0] W_BOTH    = 3'd3;
  localparam logic [2:0] W_RESP    = 3'd4;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_RESP = 1'b1;

  logic [2:0]              r_wst, w_wst_nxt;
  logic                    r_aw_rdy, r_w_rdy, r_b_vld;
  logic [1:0]              r_b_resp;
  logic [5:0]              r_awidx;
  logic [AxiDataWidth-1:0] r_wdata;
  logic [AxiStrbWidth-1:0] r_wstrb;
  logic                    r_rst, r_ar_rdy, r_r_vld;
  logic [1:0]              r_r_resp;
  logic [AxiDataWidth-1:0] r_rdata;
  logic                    r_enable;
  logic [31:0]             r_timeout, r_scratch, r_cnt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_commit, w_clear, w_werr, w_rerr;
  logic w_sel_ctrl, w_sel_tmo, w_sel_scr;
  logic [5:0]  w_wlane, w_ridx, w_rlane;
  logic [3:0]  w_ws;
  logic [31:0] w_wd, w_rd32;
  logic        w_unused;

  function automatic logic [31:0] f_merge(
    input logic [31:0] i_old,
    input logic [31:0] i_new,
    input logic [3:0]  i_be
  );
    logic [31:0] v;
    v = i_old;
    for (int k = 0; k < 4; k++)
      if (i_be[k]) v[8*k +: 8] = i_new[8*k +: 8];
    return v;
  endfunction

  assign w_aw_hs = bus.aw_valid_i & r_aw_rdy;
  assign w_w_hs  = bus.w_valid_i & r_w_rdy;
  assign w_b_hs  = r_b_vld & bus.b_ready_i;
  assign w_ar_hs = bus.ar_valid_i & r_ar_rdy;
  assign w_r_hs  = r_r_vld & bus.r_ready_i;

  // Write path
  always_comb begin
    w_wst_nxt = r_wst;
    case (r_wst)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wst_nxt = W_BOTH;
        else if (w_aw_hs)      w_wst_nxt = W_HAVE_AW;
        else if (w_w_hs)       w_wst_nxt = W_HAVE_W;
      end
      W_HAVE_AW: if (w_w_hs)  w_wst_nxt = W_BOTH;
      W_HAVE_W:  if (w_aw_hs) w_wst_nxt = W_BOTH;
      W_BOTH:    w_wst_nxt = W_RESP;
      W_RESP:    if (w_b_hs)  w_wst_nxt = W_IDLE;
      default:   w_wst_nxt = W_IDLE;
    endcase
  end

  assign w_commit   = (r_wst == W_BOTH);
  assign w_wlane    = r_awidx & LaneMask;
  assign w_ws       = 4'(r_wstrb >> {w_wlane, 2'b00});
  assign w_wd       = 32'(r_wdata >> {w_wlane, 5'b0});
  assign w_sel_ctrl = (r_awidx == 6'd0);
  assign w_sel_tmo  = (r_awidx == 6'd3);
  assign w_sel_scr  = (r_awidx == 6'd4);
  assign w_werr     = ~(w_sel_ctrl | w_sel_tmo | w_sel_scr);
  // clear is a self-clearing strobe; it is never stored
  assign w_clear    = w_commit & w_sel_ctrl & w_ws[0] & w_wd[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wst    <= W_IDLE;
      r_aw_rdy <= 1'b0;
      r_w_rdy  <= 1'b0;
      r_b_vld  <= 1'b0;
      r_b_resp <= 2'b00;
      r_awidx  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      r_wst    <= w_wst_nxt;
      // readies follow the next state so they are registered outputs
      r_aw_rdy <= (w_wst_nxt == W_IDLE) || (w_wst_nxt == W_HAVE_W);
      r_w_rdy  <= (w_wst_nxt == W_IDLE) || (w_wst_nxt == W_HAVE_AW);
      if (w_aw_hs) r_awidx <= bus.aw_addr_i[7:2];
      if (w_w_hs) begin
        r_wdata <= bus.w_data_i;
        r_wstrb <= bus.w_strb_i;
      end
      if (w_commit) begin
        r_b_vld  <= 1'b1;
        r_b_resp <= w_werr ? 2'b10 : 2'b00;
      end else if (w_b_hs) begin
        r_b_vld  <= 1'b0;
      end
    end
  end

  // Register file and mismatch counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enable  <= 1'b0;
      r_timeout <= TimeoutRst;
      r_scratch <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_commit && w_sel_ctrl && w_ws[0]) r_enable <= w_wd[0];
      if (w_commit && w_sel_tmo)
        r_timeout <= f_merge(r_timeout, w_wd, w_ws);
      if (w_commit && w_sel_scr)
        r_scratch <= f_merge(r_scratch, w_wd, w_ws);
      if (w_clear)
        r_cnt <= '0;
      else if (r_enable && mismatch_i && !(&r_cnt))
        r_cnt <= r_cnt + 32'd1;
    end
  end

  // Read path
  assign w_ridx  = bus.ar_addr_i[7:2];
  assign w_rlane = w_ridx & LaneMask;

  always_comb begin
    w_rd32 = '0;
    w_rerr = 1'b0;
    unique case (1'b1)
      (w_ridx == 6'd0): w_rd32 = {31'b0, r_enable};
      (w_ridx == 6'd1): w_rd32 = {24'b0, status_i};
      (w_ridx == 6'd2): w_rd32 = r_cnt;
      (w_ridx == 6'd3): w_rd32 = r_timeout;
      (w_ridx == 6'd4): w_rd32 = r_scratch;
      default:          w_rerr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rst    <= R_IDLE;
      r_ar_rdy <= 1'b0;
      r_r_vld  <= 1'b0;
      r_r_resp <= 2'b00;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rst    <= R_RESP;
      r_ar_rdy <= 1'b0;
      r_r_vld  <= 1'b1;
      r_r_resp <= w_rerr ? 2'b10 : 2'b00;
      r_rdata  <= AxiDataWidth'(w_rd32) << {w_rlane, 5'b0};
    end else if (w_r_hs) begin
      r_rst    <= R_IDLE;
      r_ar_rdy <= 1'b1;
      r_r_vld  <= 1'b0;
    end else if (r_rst == R_IDLE) begin
      r_ar_rdy <= 1'b1;
    end
  end

  assign bus.aw_ready_o = r_aw_rdy;
  assign bus.w_ready_o  = r_w_rdy;
  assign bus.b_valid_o  = r_b_vld;
  assign bus.b_resp_o   = r_b_resp;
  assign bus.ar_ready_o = r_ar_rdy;
  assign bus.r_valid_o  = r_r_vld;
  assign bus.r_resp_o   = r_r_resp;
  assign bus.r_data_o   = r_rdata;
  assign enable_o       = r_enable;
  assign timeout_o      = r_timeout;

  assign w_unused = ^{bus.aw_prot_i, bus.ar_prot_i,
                      bus.aw_addr_i[AxiAddrWidth-1:8],
                      bus.aw_addr_i[1:0],
                      bus.ar_addr_i[AxiAddrWidth-1:8],
                      bus.ar_addr_i[1:0]};
endmodule

// File: tb/tb_axi_lite_rvc_regs.sv
// Directed bench for axi_lite_rvc_regs.
// Each task drives one scenario and checks inline.
module tb_axi_lite_rvc_regs;
  logic clk;
  logic rst_n;
  logic [7:0] status;
  logic mismatch;
  logic enable;
  logic [31:0] timeout;
  int errors = 0;
  int checks = 0;

  axi_lite_rvc_regs_if #(
    .AxiAddrWidth(32), .AxiDataWidth(128), .AxiStrbWidth(16)
  ) bus ();

  axi_lite_rvc_regs #(
    .AxiAddrWidth(32), .AxiDataWidth(128),
    .AxiStrbWidth(16), .TimeoutRst(32'h0000_FFFF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .status_i(status), .mismatch_i(mismatch),
    .enable_o(enable), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d,
                          input logic [15:0] s, input bit pulse,
                          output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, a_hs, w_hs, bv;
    int n;
    ok = 1; aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
    bus.aw_addr_i = a; bus.aw_valid_i = 1;
    bus.w_data_i = d; bus.w_strb_i = s; bus.w_valid_i = 1;
    while (!(aw_done && w_done) && ok) begin
      a_hs = bus.aw_valid_i & bus.aw_ready_o;
      w_hs = bus.w_valid_i & bus.w_ready_o;
      tick();
      if (a_hs) begin aw_done = 1; bus.aw_valid_i = 0; end
      if (w_hs) begin w_done = 1; bus.w_valid_i = 0; end
      if (++n > 40) ok = 0;
    end
    bus.aw_valid_i = 0; bus.w_valid_i = 0;
    if (pulse) mismatch = 1;
    bus.b_ready_i = 1; n = 0; bv = 0;
    while (!bv && ok) begin
      bv = bus.b_valid_o; resp = bus.b_resp_o;
      tick();
      mismatch = 0;
      if (++n > 40) ok = 0;
    end
    bus.b_ready_i = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [127:0] d,
                         output logic [1:0] resp, output bit ok);
    bit a_hs, rv;
    int n;
    ok = 1; n = 0; a_hs = 0; d = 'x; resp = 2'bxx;
    bus.ar_addr_i = a; bus.ar_valid_i = 1;
    while (!a_hs && ok) begin
      a_hs = bus.ar_ready_o;
      tick();
      if (++n > 40) ok = 0;
    end
    bus.ar_valid_i = 0; bus.r_ready_i = 1; n = 0; rv = 0;
    while (!rv && ok) begin
      rv = bus.r_valid_o; d = bus.r_data_o; resp = bus.r_resp_o;
      tick();
      if (++n > 40) ok = 0;
    end
    bus.r_ready_i = 0;
  endtask

  task automatic test_reset();
    logic [2:0] rdy;
    rst_n = 1; #2; rst_n = 0; #10;
    checks++;
    if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o,
         bus.b_valid_o, bus.r_valid_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b want 00000",
        {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o,
         bus.b_valid_o, bus.r_valid_o});
    end
    checks++;
    if ({bus.b_resp_o, bus.r_resp_o, bus.r_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", bus.r_data_o);
    end
    checks++;
    if ({enable, timeout} !== {1'b0, 32'h0000_FFFF}) begin
      errors++;
      $display("FAIL reset_regs: got %b %h want 0 0000ffff",
               enable, timeout);
    end
    #1; rst_n = 1; #1;
    checks++;
    if (bus.aw_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rdy_pre_edge: got %b want 0", bus.aw_ready_o);
    end
    tick();
    rdy = {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o};
    checks++;
    if (rdy !== 3'b111) begin
      errors++;
      $display("FAIL rdy_first_edge: got %b want 111", rdy);
    end
  endtask

  task automatic test_same_cycle();
    logic [127:0] d;
    logic [1:0] rr;
    bit ok;
    bus.aw_addr_i = 32'hFFFC_010C; bus.aw_valid_i = 1;
    bus.w_data_i = {32'h1234_5678, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    bus.w_strb_i = 16'hF000; bus.w_valid_i = 1;
    tick();
    bus.aw_valid_i = 0; bus.w_valid_i = 0;
    checks++;
    if (bus.b_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sc_bvalid_early: got %b want 0", bus.b_valid_o);
    end
    tick();
    checks++;
    if ({bus.b_valid_o, bus.b_resp_o} !== 3'b100) begin
      errors++;
      $display("FAIL sc_bresp: got %b want 100",
               {bus.b_valid_o, bus.b_resp_o});
    end
    checks++;
    if (timeout !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sc_timeout: got %h want 12345678", timeout);
    end
    bus.b_ready_i = 1; tick(); bus.b_ready_i = 0;
    checks++;
    if ({bus.b_valid_o, bus.aw_ready_o, bus.w_ready_o} !== 3'b011) begin
      errors++;
      $display("FAIL sc_after_b: got %b want 011",
               {bus.b_valid_o, bus.aw_ready_o, bus.w_ready_o});
    end
    do_read(32'hFFFC_010C, d, rr, ok);
    checks++;
    if (!ok || rr !== 2'b00 || d !== {32'h1234_5678, 96'h0}) begin
      errors++;
      $display("FAIL sc_read: got %h/%b want %h/00",
               d, rr, {32'h1234_5678, 96'h0});
    end
  endtask

  task automatic test_w_first();
    logic [127:0] d;
    logic [1:0] rr;
    bit ok;
    bus.w_data_i = 128'hFFFF_FFAB; bus.w_strb_i = 16'h0001;
    bus.w_valid_i = 1;
    tick();
    bus.w_valid_i = 0;
    checks++;
    if (bus.w_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL wf_wready: got %b want 0", bus.w_ready_o);
    end
    tick();
    bus.aw_addr_i = 32'hFFFC_0110; bus.aw_valid_i = 1;
    tick();
    tick();
    checks++;
    if ({bus.b_valid_o, bus.b_resp_o} !== 3'b100) begin
      errors++;
      $display("FAIL wf_bresp: got %b want 100",
               {bus.b_valid_o, bus.b_resp_o});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.aw_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL wf_aw_blocked%0d: got %b want 0",
                 i, bus.aw_ready_o);
      end
      tick();
    end
    bus.b_ready_i = 1; tick(); bus.b_ready_i = 0;
    bus.aw_valid_i = 0;
    checks++;
    if ({bus.b_valid_o, bus.aw_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL wf_after_b: got %b want 01",
               {bus.b_valid_o, bus.aw_ready_o});
    end
    do_read(32'hFFFC_0110, d, rr, ok);
    checks++;
    if (!ok || rr !== 2'b00 || d !== 128'hAB) begin
      errors++;
      $display("FAIL wf_scratch: got %h/%b want ab/00", d, rr);
    end
  endtask

  task automatic test_mismatch();
    logic [127:0] d;
    logic [1:0] rr;
    bit ok;
    do_write(32'hFFFC_0100, 128'h1, 16'h000F, 0, rr, ok);
    checks++;
    if (!ok || rr !== 2'b00 || enable !== 1'b1) begin
      errors++;
      $display("FAIL mm_enable: got %b/%b want 1/00", enable, rr);
    end
    repeat (5) begin
      mismatch = 1; tick(); mismatch = 0; tick();
    end
    do_read(32'hFFFC_0108, d, rr, ok);
    checks++;
    if (!ok || d !== {32'h0, 32'd5, 64'h0}) begin
      errors++;
      $display("FAIL mm_count5: got %h want %h", d,
               {32'h0, 32'd5, 64'h0});
    end
    do_write(32'hFFFC_0100, 128'h3, 16'h000F, 1, rr, ok);
    do_read(32'hFFFC_0108, d, rr, ok);
    checks++;
    if (!ok || d !== 128'h0 || enable !== 1'b1) begin
      errors++;
      $display("FAIL mm_clear: got %h en=%b want 0 en=1", d, enable);
    end
    do_read(32'hFFFC_0100, d, rr, ok);
    checks++;
    if (!ok || rr !== 2'b00 || d !== 128'h1) begin
      errors++;
      $display("FAIL mm_ctrl_read: got %h want 1", d);
    end
    repeat (2) begin
      mismatch = 1; tick(); mismatch = 0; tick();
    end
    do_read(32'hFFFC_0108, d, rr, ok);
    checks++;
    if (!ok || d !== {32'h0, 32'd2, 64'h0}) begin
      errors++;
      $display("FAIL mm_count2: got %h want %h", d,
               {32'h0, 32'd2, 64'h0});
    end
    do_write(32'hFFFC_0100, 128'h0, 16'h000F, 0, rr, ok);
    mismatch = 1; tick(); mismatch = 0; tick();
    do_read(32'hFFFC_0108, d, rr, ok);
    checks++;
    if (!ok || enable !== 1'b0 || d !== {32'h0, 32'd2, 64'h0}) begin
      errors++;
      $display("FAIL mm_hold: got %h en=%b want %h en=0", d, enable,
               {32'h0, 32'd2, 64'h0});
    end
  endtask

  task automatic test_errors();
    logic [127:0] d;
    logic [1:0] rr;
    bit ok;
    do_read(32'hFFFC_01F0, d, rr, ok);
    checks++;
    if (!ok || rr !== 2'b10 || d !== 128'h0) begin
      errors++;
      $display("FAIL err_read: got %h/%b want 0/10", d, rr);
    end
    do_write(32'hFFFC_0104, '1, 16'hFFFF, 0, rr, ok);
    checks++;
    if (!ok || rr !== 2'b10) begin
      errors++;
      $display("FAIL err_write_ro: got %b want 10", rr);
    end
    status = 8'h5A;
    do_read(32'hFFFC_0104, d, rr, ok);
    checks++;
    if (!ok || rr !== 2'b00 || d !== {64'h0, 32'h5A, 32'h0}) begin
      errors++;
      $display("FAIL err_status: got %h/%b want %h/00", d, rr,
               {64'h0, 32'h5A, 32'h0});
    end
  endtask

  task automatic test_r_stall();
    status = 8'h5A;
    bus.ar_addr_i = 32'hFFFC_0104; bus.ar_valid_i = 1;
    tick();
    bus.ar_valid_i = 0;
    status = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.r_valid_o, bus.ar_ready_o, bus.r_resp_o} !== 4'b1000 ||
          bus.r_data_o !== {64'h0, 32'h5A, 32'h0}) begin
        errors++;
        $display("FAIL stall%0d: got %b %h want 1000 %h", i,
                 {bus.r_valid_o, bus.ar_ready_o, bus.r_resp_o},
                 bus.r_data_o, {64'h0, 32'h5A, 32'h0});
      end
      if (i < 4) tick();
    end
    bus.r_ready_i = 1; tick(); bus.r_ready_i = 0;
    checks++;
    if ({bus.r_valid_o, bus.ar_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL stall_done: got %b want 01",
               {bus.r_valid_o, bus.ar_ready_o});
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    logic [1:0] rr;
    bit ok;
    bus.aw_addr_i = 32'hFFFC_0110; bus.aw_valid_i = 1;
    bus.w_data_i = 128'hDEAD_BEEF; bus.w_strb_i = 16'h000F;
    bus.w_valid_i = 1;
    tick();
    bus.aw_valid_i = 0; bus.w_valid_i = 0;
    tick();
    checks++;
    if (bus.b_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rm_bvalid: got %b want 1", bus.b_valid_o);
    end
    #2; rst_n = 0; #1;
    checks++;
    if ({bus.b_valid_o, bus.aw_ready_o, bus.ar_ready_o} !== 3'b000 ||
        timeout !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL rm_async: got %b %h want 000 0000ffff",
               {bus.b_valid_o, bus.aw_ready_o, bus.ar_ready_o},
               timeout);
    end
    #2; rst_n = 1;
    tick();
    do_read(32'hFFFC_010C, d, rr, ok);
    checks++;
    if (!ok || d !== {32'h0000_FFFF, 96'h0}) begin
      errors++;
      $display("FAIL rm_timeout: got %h want %h", d,
               {32'h0000_FFFF, 96'h0});
    end
    do_read(32'hFFFC_0110, d, rr, ok);
    checks++;
    if (!ok || d !== 128'h0) begin
      errors++;
      $display("FAIL rm_scratch: got %h want 0", d);
    end
    do_read(32'hFFFC_0108, d, rr, ok);
    checks++;
    if (!ok || d !== 128'h0) begin
      errors++;
      $display("FAIL rm_count: got %h want 0", d);
    end
  endtask

  initial begin
    status = 8'h00; mismatch = 0;
    bus.aw_addr_i = '0; bus.aw_prot_i = '0; bus.aw_valid_i = 0;
    bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_valid_i = 0;
    bus.b_ready_i = 0;
    bus.ar_addr_i = '0; bus.ar_prot_i = '0; bus.ar_valid_i = 0;
    bus.r_ready_i = 0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_mismatch();
    test_errors();
    test_r_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
